// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths and FSM encoding for the cache 0 controller
package cache_pkg;

    localparam int ADDR_WIDTH  = 8;
    localparam int INDEX_WIDTH = 3;
    localparam int DWIDTH      = 32;
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

endpackage

// File: rtl/cache_0_tag.sv
// rtl/cache_0_tag.sv - tag and valid store, async read, sync write
module cache_0_tag
    import cache_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   rd_valid,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [TAG_WIDTH-1:0] tags [DEPTH];
    logic [DEPTH-1:0]     valid;

    // Tags need no reset: a cleared valid bit masks whatever tag is stored.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    // Valid bits clear immediately on reset and are set by each refill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/cache_0_ctrl.sv
// rtl/cache_0_ctrl.sv - direct-mapped write-through cache controller for cache 0
module cache_0_ctrl
    import cache_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
    input  logic [DWIDTH-1:0]      cpu_req_wdata,
    output logic                   cpu_resp_valid,
    output logic [DWIDTH-1:0]      cpu_resp_rdata,
    output logic                   mem_req_valid,
    output logic                   mem_req_we,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    output logic [DWIDTH-1:0]      mem_req_wdata,
    input  logic                   mem_resp_valid,
    input  logic [DWIDTH-1:0]      mem_resp_rdata,
    output logic [INDEX_WIDTH-1:0] dary_addr,
    output logic [DWIDTH-1:0]      dary_wdata,
    output logic                   dary_we,
    input  logic [DWIDTH-1:0]      dary_rdata,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic [CNT_WIDTH-1:0]   miss_count
);

    state_t                 state;
    logic                   req_we;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DWIDTH-1:0]      req_wdata;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [TAG_WIDTH-1:0]   stored_tag;
    logic                   stored_valid;
    logic                   hit;
    logic                   fill;

    assign req_idx = req_addr[INDEX_WIDTH-1:0];
    assign req_tag = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign hit     = stored_valid && (stored_tag == req_tag);
    assign fill    = (state == ST_MEM_RD) && mem_resp_valid;

    cache_0_tag u_tag (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_idx   (req_idx),
        .rd_tag   (stored_tag),
        .rd_valid (stored_valid),
        .wr_en    (fill),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag)
    );

    assign cpu_req_ready = (state == ST_IDLE);

    // In IDLE the array is addressed straight from the CPU so its data is ready in LOOKUP.
    assign dary_addr = (state == ST_IDLE) ? cpu_req_addr[INDEX_WIDTH-1:0] : req_idx;

    assign mem_req_valid = (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign mem_req_we    = (state == ST_MEM_WR);
    assign mem_req_addr  = mem_req_valid ? req_addr : '0;
    assign mem_req_wdata = mem_req_we ? req_wdata : '0;

    // Array writes happen only on a write hit in LOOKUP or on a refill acknowledge.
    always_comb begin
        dary_we    = 1'b0;
        dary_wdata = '0;
        if ((state == ST_LOOKUP) && req_we && hit) begin
            dary_we    = 1'b1;
            dary_wdata = req_wdata;
        end else if (fill) begin
            dary_we    = 1'b1;
            dary_wdata = mem_resp_rdata;
        end
    end

    // Main FSM: request capture, hit/miss decision, memory handshakes and statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        req_we    <= cpu_req_we;
                        req_addr  <= cpu_req_addr;
                        req_wdata <= cpu_req_wdata;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 1'b1;
                        end
                        if (req_we) begin
                            state <= ST_MEM_WR;
                        end else begin
                            cpu_resp_valid <= 1'b1;
                            cpu_resp_rdata <= dary_rdata;
                            state          <= ST_IDLE;
                        end
                    end else begin
                        if (miss_count != '1) begin
                            miss_count <= miss_count + 1'b1;
                        end
                        state <= req_we ? ST_MEM_WR : ST_MEM_RD;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_resp_valid) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= mem_resp_rdata;
                        state          <= ST_IDLE;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_resp_valid) begin
                        cpu_resp_valid <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_0_ctrl.sv
// tb/tb_cache_0_ctrl.sv - self-checking bench for cache_0_ctrl
module tb_cache_0_ctrl;
    import cache_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req_valid, cpu_req_we;
    logic [7:0]  cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] dary_rdata;

    logic        cpu_req_ready, cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid, mem_req_we;
    logic [7:0]  mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [2:0]  dary_addr;
    logic [31:0] dary_wdata;
    logic        dary_we;
    logic [15:0] hit_count, miss_count;

    logic        s_ready, s_resp_valid, s_mem_valid, s_mem_we, s_dary_we;
    logic [31:0] s_resp_rdata, s_mem_wdata, s_dary_wdata;
    logic [7:0]  s_mem_addr;
    logic [2:0]  s_dary_addr;
    logic [2:0]  s_hit_count, s_miss_count;

    always #5 clock = ~clock;

    cache_0_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .dary_addr(dary_addr), .dary_wdata(dary_wdata), .dary_we(dary_we),
        .dary_rdata(dary_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_0_ctrl #(.CNT_WIDTH(3)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(s_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(s_resp_valid), .cpu_resp_rdata(s_resp_rdata),
        .mem_req_valid(s_mem_valid), .mem_req_we(s_mem_we),
        .mem_req_addr(s_mem_addr), .mem_req_wdata(s_mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .dary_addr(s_dary_addr), .dary_wdata(s_dary_wdata), .dary_we(s_dary_we),
        .dary_rdata(dary_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    logic [31:0] ram [8];
    always @(posedge clock) begin
        if (dary_we) ram[dary_addr] <= dary_wdata;
        dary_rdata <= ram[dary_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    logic [31:0] mem_env [256];
    logic [31:0] mem_ref [256];
    logic        mv [8];
    logic [4:0]  mt [8];
    logic [31:0] md [8];
    int          hc, mc;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        hc = 0;
        mc = 0;
    endtask

    task automatic model_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                             output logic hit, output logic [31:0] rd);
        int idx;
        idx = int'(addr % 8);
        hit = mv[idx] && (mt[idx] == addr[7:3]);
        if (hit) hc++; else mc++;
        rd = 32'h0;
        if (we) begin
            mem_ref[addr] = wdata;
            if (hit) md[idx] = wdata;
        end else if (hit) begin
            rd = md[idx];
        end else begin
            rd = mem_ref[addr];
            md[idx] = rd;
            mt[idx] = addr[7:3];
            mv[idx] = 1'b1;
        end
    endtask

    typedef struct {
        logic        rdy, got, stable, mwe;
        logic [31:0] rdata, dwe_data, mwdata;
        logic [2:0]  dwe_addr;
        logic [7:0]  maddr;
        int          lat, nmem, ndwe;
    } res_t;

    task automatic run_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                           input int dly, output res_t r);
        int   waited;
        logic seen;
        r = '{default: 0};
        r.stable = 1'b1;
        waited = 0;
        seen = 1'b0;
        @(negedge clock);
        r.rdy = cpu_req_ready;
        cpu_req_valid = 1'b1;
        cpu_req_we = we;
        cpu_req_addr = addr;
        cpu_req_wdata = wdata;
        @(posedge clock);
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            r.lat++;
            cpu_req_valid = 1'b0;
            mem_resp_valid = 1'b0;
            if (mem_req_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    r.maddr = mem_req_addr;
                end
                if (mem_req_addr != r.maddr) r.stable = 1'b0;
                if (waited == dly) begin
                    mem_resp_valid = 1'b1;
                    r.nmem++;
                    r.mwe = mem_req_we;
                    r.mwdata = mem_req_wdata;
                    if (mem_req_we) begin
                        mem_env[mem_req_addr] = mem_req_wdata;
                        mem_resp_rdata = $urandom;
                    end else begin
                        mem_resp_rdata = mem_env[mem_req_addr];
                    end
                    waited = 0;
                    seen = 1'b0;
                end else begin
                    waited++;
                end
            end
            #1;
            if (dary_we) begin
                r.ndwe++;
                r.dwe_addr = dary_addr;
                r.dwe_data = dary_wdata;
            end
            if (cpu_resp_valid) begin
                r.got = 1'b1;
                r.rdata = cpu_resp_rdata;
                break;
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic check_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                             input logic hit, input logic [31:0] rd, input res_t r);
        check("req_ready", {31'h0, r.rdy}, 32'h1);
        check("resp_seen", {31'h0, r.got}, 32'h1);
        check("resp_rdata", r.rdata, rd);
        check("mem_txns", r.nmem, (we || !hit) ? 32'd1 : 32'd0);
        check("dary_we_count", r.ndwe, (we ? hit : !hit) ? 32'd1 : 32'd0);
        if (r.ndwe == 1) begin
            check("dary_addr", {29'h0, r.dwe_addr}, {29'h0, addr[2:0]});
            check("dary_wdata", r.dwe_data, we ? wdata : rd);
        end
        if (r.nmem == 1) begin
            check("mem_addr", {24'h0, r.maddr}, {24'h0, addr});
            check("mem_we", {31'h0, r.mwe}, {31'h0, we});
            check("mem_addr_stable", {31'h0, r.stable}, 32'h1);
            if (we) check("mem_wdata", r.mwdata, wdata);
        end
        if (!we && hit) check("hit_latency", r.lat, 32'd2);
    endtask

    task automatic check_counts();
        check("hit_count", {16'h0, hit_count}, sat(hc, 65535));
        check("miss_count", {16'h0, miss_count}, sat(mc, 65535));
        check("sat_hit_count", {29'h0, s_hit_count}, sat(hc, 7));
        check("sat_miss_count", {29'h0, s_miss_count}, sat(mc, 7));
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        preset;
        logic [31:0] mval;
        int          dly;
        logic        hit;
        logic [31:0] rdata;
        int          hc;
        int          mc;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic preset, input logic [31:0] mval, input int dly,
                                input logic hit, input logic [31:0] rdata, input int h, input int m);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.preset = preset; v.mval = mval;
        v.dly = dly; v.hit = hit; v.rdata = rdata; v.hc = h; v.mc = m;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        res_t        r;
        logic        ehit;
        logic [31:0] erd;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          dly;
        logic        saw;

        vecs[0] = mk(0, 8'h2A, 0,            1, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 0, 1);
        vecs[1] = mk(0, 8'h2A, 0,            0, 0,            0, 1, 32'hDEADBEEF, 1, 1);
        vecs[2] = mk(0, 8'h0A, 0,            1, 32'h11111111, 1, 0, 32'h11111111, 1, 2);
        vecs[3] = mk(0, 8'h2A, 0,            0, 0,            0, 0, 32'hDEADBEEF, 1, 3);
        vecs[4] = mk(0, 8'h0A, 0,            0, 0,            2, 0, 32'h11111111, 1, 4);
        vecs[5] = mk(1, 8'h0A, 32'h12345678, 0, 0,            2, 1, 32'h0,        2, 4);
        vecs[6] = mk(0, 8'h0A, 0,            0, 0,            0, 1, 32'h12345678, 3, 4);
        vecs[7] = mk(1, 8'h33, 32'hCAFEF00D, 0, 0,            0, 0, 32'h0,        3, 5);
        vecs[8] = mk(0, 8'h33, 0,            0, 0,            1, 0, 32'hCAFEF00D, 3, 6);

        for (int i = 0; i < 256; i++) begin
            mem_env[i] = 32'hA5000000 ^ (i * 32'h01010101);
            mem_ref[i] = mem_env[i];
        end
        reset_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 8'h0; cpu_req_wdata = 32'h0;
        mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
        model_reset();

        repeat (2) @(negedge clock);
        check("reset_ready", {31'h0, cpu_req_ready}, 32'h1);
        check("reset_resp_valid", {31'h0, cpu_resp_valid}, 32'h0);
        check("reset_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("reset_dary_we", {31'h0, dary_we}, 32'h0);
        check("reset_hit_count", {16'h0, hit_count}, 32'h0);
        check("reset_miss_count", {16'h0, miss_count}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].preset) begin
                mem_env[vecs[i].addr] = vecs[i].mval;
                mem_ref[vecs[i].addr] = vecs[i].mval;
            end
            model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, ehit, erd);
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dly, r);
            check_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hit, vecs[i].rdata, r);
            check("vec_hit_count", {16'h0, hit_count}, vecs[i].hc);
            check("vec_miss_count", {16'h0, miss_count}, vecs[i].mc);
        end

        // Stray memory acknowledge while idle must have no effect.
        @(negedge clock);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0BAD0;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        check("stray_ack_ready", {31'h0, cpu_req_ready}, 32'h1);
        check("stray_ack_resp", {31'h0, cpu_resp_valid}, 32'h0);
        check_counts();
        model_req(0, 8'h0A, 0, ehit, erd);
        run_req(0, 8'h0A, 0, 0, r);
        check_req(0, 8'h0A, 0, 1'b1, 32'h12345678, r);

        // Reset while a refill is waiting on memory.
        @(negedge clock);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 8'h52;
        @(posedge clock);
        saw = 1'b0;
        for (int c = 0; c < 10 && !saw; c++) begin
            @(negedge clock);
            cpu_req_valid = 1'b0;
            saw = mem_req_valid;
        end
        check("rst_seq_mem_req_seen", {31'h0, saw}, 32'h1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_async_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_async_ready", {31'h0, cpu_req_ready}, 32'h1);
        check("rst_async_miss_count", {16'h0, miss_count}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        model_req(0, 8'h0A, 0, ehit, erd);
        run_req(0, 8'h0A, 0, 0, r);
        check_req(0, 8'h0A, 0, 1'b0, 32'h12345678, r);
        check("post_rst_miss_count", {16'h0, miss_count}, 32'h1);
        check("post_rst_hit_count", {16'h0, hit_count}, 32'h0);

        for (int n = 0; n < 200; n++) begin
            we = ($urandom_range(0, 2) == 0);
            addr = 8'($urandom_range(0, 23));
            wdata = $urandom;
            dly = $urandom_range(0, 3);
            model_req(we, addr, wdata, ehit, erd);
            run_req(we, addr, wdata, dly, r);
            check_req(we, addr, wdata, ehit, erd, r);
            check_counts();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_0_ctrl.md
Name: cache_0_ctrl

Overview:
Direct-mapped cache controller directly upstream of the cache 0 data array; owns the tag/valid store, hit/miss decision, refill and write-through FSM.
Drives the data array's addr/data_in/write_enable and consumes its data_out, which has one cycle of read latency.
CPU side uses a valid/ready request with a one-cycle response pulse; memory side uses a request held until acknowledged.

Parameters:
ADDR_WIDTH, 8, CPU word-address width.
INDEX_WIDTH, 3, line index width; must match the data array AWIDTH (8 lines, one word per line).
DWIDTH, 32, data word width; must match the data array DWIDTH.
CNT_WIDTH, 16, width of the hit/miss statistics counters.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
cpu_req_valid  in  1  CPU request present.
cpu_req_ready  out  1  controller accepts a request (IDLE only).
cpu_req_we  in  1  1 = write, 0 = read.
cpu_req_addr  in  ADDR_WIDTH  word address; index = [INDEX_WIDTH-1:0], tag = upper bits.
cpu_req_wdata  in  DWIDTH  write data.
cpu_resp_valid  out  1  one-cycle completion pulse.
cpu_resp_rdata  out  DWIDTH  read data, valid with cpu_resp_valid on reads; 0 on writes.
mem_req_valid  out  1  memory request.
mem_req_we  out  1  memory write.
mem_req_addr  out  ADDR_WIDTH  memory word address.
mem_req_wdata  out  DWIDTH  memory write data.
mem_resp_valid  in  1  memory acknowledge; completes the request.
mem_resp_rdata  in  DWIDTH  read data, valid with mem_resp_valid.
dary_addr  out  INDEX_WIDTH  to data array addr.
dary_wdata  out  DWIDTH  to data array data_in.
dary_we  out  1  to data array write_enable.
dary_rdata  in  DWIDTH  from data array data_out.
hit_count  out  CNT_WIDTH  saturating hit counter.
miss_count  out  CNT_WIDTH  saturating miss counter.

Behaviour:
- Reset (async, reset_n=0): state IDLE, all valid bits 0, counters 0. All outputs 0 except cpu_req_ready=1. An in-flight memory request is dropped immediately. Data array contents are not reset, but cleared valid bits force misses.
- States: IDLE, LOOKUP, MEM_RD, MEM_WR.
- IDLE:
  - cpu_req_ready=1.
  - dary_addr is combinationally the index of cpu_req_addr, so array data is ready in LOOKUP.
  - On cpu_req_valid: latch we/addr/wdata and go to LOOKUP.
- LOOKUP (one cycle): dary_addr = latched index; hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: cpu_resp_valid=1, cpu_resp_rdata=dary_rdata, hit_count+1, go to IDLE. Total latency is 2 cycles from acceptance.
  - Read miss: miss_count+1, go to MEM_RD.
  - Write hit: dary_we=1, dary_wdata=req_wdata, hit_count+1, go to MEM_WR.
  - Write miss: miss_count+1, no allocate, array and tags untouched, go to MEM_WR.
- MEM_RD:
  - mem_req_valid=1, we=0, addr=req_addr, held stable until mem_resp_valid.
  - On mem_resp_valid in the same cycle: dary_we=1, dary_wdata=mem_resp_rdata; tag[idx]=req_tag, valid[idx]=1; cpu_resp_valid=1, cpu_resp_rdata=mem_resp_rdata; go to IDLE.
- MEM_WR (write-through):
  - mem_req_valid=1, we=1, addr=req_addr, wdata=req_wdata, held until mem_resp_valid.
  - On mem_resp_valid: cpu_resp_valid=1 and go to IDLE.
- mem_resp_valid outside MEM_RD/MEM_WR is ignored.
- Memory acknowledge may arrive in the first request cycle (zero wait); latency is unbounded with no timeout.
- No CPU backpressure: the response pulse is lost if not sampled.
- One request is outstanding at a time; cpu_req_valid in non-IDLE states is not accepted.
- Counters saturate at all-ones and do not wrap.
- dary_we is asserted only in the two cases above. dary_addr is always the latched index outside IDLE.

Decomposition:
- Shared package cache_pkg holds: width constants (ADDR_WIDTH, INDEX_WIDTH, DWIDTH, TAG_WIDTH=ADDR_WIDTH-INDEX_WIDTH) and the FSM state encoding.
- One sub-module, cache_0_tag: 2^INDEX_WIDTH entries of tag+valid.
  - Asynchronous read.
  - Synchronous write.
  - Async-clear of valid bits on reset_n.

Test Plan:
- Reset, then read addr 0x2A -> miss. mem_req addr 0x2A; ack after 3 cycles with 0xDEADBEEF -> dary_we at idx 2, cpu_resp_rdata=0xDEADBEEF, miss_count=1.
- Re-read 0x2A -> resp 2 cycles after acceptance with 0xDEADBEEF, no mem_req, hit_count=1.
- Read 0x0A (same idx 2, different tag) -> miss and refill with 0x11111111 -> tag replaced. Subsequent read of 0x2A misses again.
- Write 0x0A = 0x12345678 (hit) -> dary_we with that data in LOOKUP. mem write to 0x0A; resp after ack. Re-read returns 0x12345678 as a hit.
- Write miss to 0x33 -> memory write only, dary_we never asserted, miss_count increments, read of 0x33 then misses.
- Assert reset_n=0 during MEM_RD wait -> mem_req_valid drops asynchronously and valid bits clear. After release, a read of 0x0A misses.
